// File: rtl/text_buffer_ctrl.sv
// Character/attribute text buffer: scrolled display read port, CPU req/ready
// port and a one-cell-per-clock full-screen fill engine sharing RAM port A.
module text_buffer_ctrl #(
  parameter int    COLS    = 80,
  parameter int    ROWS    = 30,
  parameter int    CHAR_W  = 8,
  parameter int    ATTR_W  = 8,
  parameter string MEMFILE = "",
  localparam int   CW      = CHAR_W + ATTR_W,
  localparam int   DEPTH   = COLS * ROWS,
  localparam int   AW      = $clog2(DEPTH),
  localparam int   CA      = $clog2(COLS),
  localparam int   RA      = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [CW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [CW-1:0] cpu_rdata,
  input  logic          disp_en,
  input  logic [CA-1:0] disp_col,
  input  logic [RA-1:0] disp_row,
  output logic [CW-1:0] disp_data,
  input  logic          scroll_we,
  input  logic [RA-1:0] scroll_val,
  input  logic          fill_start,
  input  logic [CW-1:0] fill_value,
  output logic          fill_busy,
  output logic          fill_done
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] COLS_A  = AW'(COLS);
  localparam logic [RA:0]   ROWS_W  = (RA+1)'(ROWS);
  localparam logic [RA-1:0] ROW_MAX = RA'(ROWS - 1);

  logic [CW-1:0] mem_r [DEPTH];

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] cursor_r;
  logic [CW-1:0] fill_val_r;
  logic [RA-1:0] scroll_r;
  logic          busy_r, done_r, rvalid_r;
  logic [CW-1:0] rdata_r, disp_r;

  logic          fill_go_s, fill_last_s;
  logic          cpu_acc_s, cpu_addr_ok_s, disp_ok_s;
  logic [RA:0]   row_sum_s, row_wrap_s;
  logic [AW-1:0] disp_addr_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_waddr_s;
  logic [CW-1:0] ram_wdata_s;

  // Fill FSM next-state: fill_start wins over the CPU while idle.
  always_comb begin
    state_nxt_s = state_r;
    fill_go_s   = 1'b0;
    fill_last_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fill_start) begin
          fill_go_s   = 1'b1;
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (cursor_r == LAST_A) begin
          fill_last_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign cpu_ready     = cpu_req & (state_r == ST_IDLE) & ~fill_start;
  assign cpu_acc_s     = cpu_ready;
  assign cpu_addr_ok_s = (int'(cpu_addr) < DEPTH);

  // Port A arbitration: the fill engine owns the port while filling.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = cpu_addr;
    ram_wdata_s = cpu_wdata;
    if (state_r == ST_FILL) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = cursor_r;
      ram_wdata_s = fill_val_r;
    end else if (cpu_acc_s && cpu_we && cpu_addr_ok_s) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Display address: logical row plus scroll offset, wrapped modulo ROWS.
  always_comb begin
    row_sum_s  = {1'b0, disp_row} + {1'b0, scroll_r};
    row_wrap_s = row_sum_s;
    if (int'(row_sum_s) >= ROWS) begin
      row_wrap_s = row_sum_s - ROWS_W;
    end else begin
      row_wrap_s = row_sum_s;
    end
    disp_addr_s = AW'(row_wrap_s[RA-1:0]) * COLS_A + AW'(disp_col);
    disp_ok_s   = (int'(disp_col) < COLS) && (int'(disp_row) < ROWS);
  end

  // RAM port A write; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_waddr_s] <= ram_wdata_s;
    end
  end

  // Fill FSM state, cursor and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cursor_r   <= '0;
      fill_val_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_FILL);
      done_r  <= fill_last_s;
      if (fill_go_s) begin
        fill_val_r <= fill_value;
        cursor_r   <= '0;
      end else if (state_r == ST_FILL) begin
        cursor_r <= cursor_r + AW'(1);
      end
    end
  end

  // CPU read data; out-of-range reads still answer, with zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      rvalid_r <= cpu_acc_s & ~cpu_we;
      if (cpu_acc_s && !cpu_we) begin
        rdata_r <= cpu_addr_ok_s ? mem_r[cpu_addr] : '0;
      end
    end
  end

  // Display read port (old data on a same-cycle write) and scroll offset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_r   <= '0;
      scroll_r <= '0;
    end else begin
      if (disp_en) begin
        disp_r <= disp_ok_s ? mem_r[disp_addr_s] : '0;
      end
      if (scroll_we) begin
        scroll_r <= (int'(scroll_val) >= ROWS) ? ROW_MAX : scroll_val;
      end
    end
  end

  assign cpu_rvalid = rvalid_r;
  assign cpu_rdata  = rdata_r;
  assign disp_data  = disp_r;
  assign fill_busy  = busy_r;
  assign fill_done  = done_r;

endmodule
